mult_ctrl_taint_gen: RTL

- Parametrised next-generation control FSM for the shift-add sequential multiplier, with bitwise taint tracking on every control output.
- Adds to the previous control block:
  - a counter-based FSM, so the state count is independent of WIDTH;
  - a signed (two's-complement) mode;
  - a zero-multiplier shortcut;
  - a held done/ack handshake;
  - precise taint clearing and a sticky taint flag.
- Sits between the start/ack host interface and the multiplier datapath (product shift register, multiplier and multiplicand registers).

---
 rtl/mult_ctrl_pkg.sv | 36 +++
 rtl/taint_state_reg.sv | 39 +++
 rtl/mult_ctrl_taint_gen.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mult_ctrl_pkg.sv
// Shared types and helpers for the tainted shift-add multiplier control block.
package mult_ctrl_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        TEST  = 3'd2,
        ADD   = 3'd3,
        SHIFT = 3'd4,
        DONE  = 3'd5
    } state_e;

    // Registered datapath strobes and handshake outputs
    typedef struct packed {
        logic busy;
        logic done;
        logic rsload;
        logic rssub;
        logic rsclear;
        logic rsshr;
        logic mrld;
        logic mdld;
    } ctrl_out_t;

    function automatic int unsigned cnt_width(input int unsigned width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

    // Fold one taint source into every bit of a state-taint vector
    function automatic logic [STATE_W-1:0] taint_or(input logic [STATE_W-1:0] t, input logic src);
        return t | {STATE_W{src}};
    endfunction

endpackage

// File: rtl/taint_state_reg.sv
// State, bit counter and their taint shadows, with a clear for the DONE->IDLE reconvergence.
module taint_state_reg
    import mult_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  state_e               state_d,
    input  logic [CNT_W-1:0]     cnt_d,
    input  logic [STATE_W-1:0]   state_t_d,
    input  logic [CNT_W-1:0]     cnt_t_d,
    input  logic                 clear_t,
    output state_e               state_q,
    output logic [CNT_W-1:0]     cnt_q,
    output logic [STATE_W-1:0]   state_t_q,
    output logic [CNT_W-1:0]     cnt_t_q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            state_t_q <= '0;
            cnt_t_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (clear_t) begin
                state_t_q <= '0;
                cnt_t_q   <= '0;
            end else begin
                state_t_q <= state_t_d;
                cnt_t_q   <= cnt_t_d;
            end
        end
    end

endmodule

// File: rtl/mult_ctrl_taint_gen.sv
// Counter-based shift-add multiplier control FSM with signed mode, zero shortcut,
// held done/ack handshake and bitwise taint on every control output.
module mult_ctrl_taint_gen
    import mult_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter bit          SIGNED_EN  = 1'b1,
    parameter bit          EARLY_ZERO = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             start_t,
    input  logic             signed_mode,
    input  logic             signed_mode_t,
    input  logic             ack,
    input  logic             ack_t,
    input  logic [WIDTH-1:0] multiplierReg,
    input  logic [WIDTH-1:0] multiplierReg_t,
    output logic             busy,
    output logic             busy_t,
    output logic             productDone,
    output logic             productDone_t,
    output logic             rsload,
    output logic             rsload_t,
    output logic             rssub,
    output logic             rssub_t,
    output logic             rsclear,
    output logic             rsclear_t,
    output logic             rsshr,
    output logic             rsshr_t,
    output logic             mrld,
    output logic             mrld_t,
    output logic             mdld,
    output logic             mdld_t,
    output logic             taint_seen
);

    localparam int unsigned      CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [STATE_W-1:0]   state_t_q, state_t_d;
    logic [CNT_W-1:0]     cnt_t_q, cnt_t_d;
    logic                 clear_t;
    logic                 last;

    ctrl_out_t            out_q, out_d;
    logic                 ctrl_t_q, ctrl_t_d;
    logic                 taint_seen_q, taint_seen_d;
    logic                 sub_sel;

    taint_state_reg #(.CNT_W(CNT_W)) u_state_reg (
        .clk       (clk),
        .rst       (rst),
        .state_d   (state_d),
        .cnt_d     (cnt_d),
        .state_t_d (state_t_d),
        .cnt_t_d   (cnt_t_d),
        .clear_t   (clear_t),
        .state_q   (state_q),
        .cnt_q     (cnt_q),
        .state_t_q (state_t_q),
        .cnt_t_q   (cnt_t_q)
    );

    assign last = (cnt_q == LAST);

    // Next state, counter and taint propagation
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        state_t_d = state_t_q;
        cnt_t_d   = cnt_t_q;
        clear_t   = 1'b0;
        case (state_q)
            IDLE: begin
                state_t_d = taint_or(state_t_q, start_t);
                if (start) state_d = INIT;
            end
            INIT: begin
                cnt_d   = '0;
                cnt_t_d = cnt_t_q | {CNT_W{|state_t_q}};
                state_d = TEST;
            end
            TEST: begin
                state_t_d = taint_or(state_t_q, multiplierReg_t[cnt_q]);
                if (EARLY_ZERO && (cnt_q == '0) && (multiplierReg == '0)) begin
                    state_d   = DONE;
                    state_t_d = taint_or(state_t_d, |multiplierReg_t);
                end else if (multiplierReg[cnt_q]) begin
                    state_d = ADD;
                end else begin
                    state_d = SHIFT;
                end
            end
            ADD: begin
                if (SIGNED_EN && last) state_t_d = taint_or(state_t_q, signed_mode_t);
                state_d = SHIFT;
            end
            SHIFT: begin
                if (last) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    cnt_t_d = cnt_t_q | {CNT_W{|state_t_q}};
                    state_d = TEST;
                end
            end
            DONE: begin
                // An untainted ack returns to a fixed state, so all control taint can be dropped
                if (ack && !ack_t) begin
                    state_d = IDLE;
                    clear_t = 1'b1;
                end else begin
                    state_t_d = taint_or(state_t_q, ack_t);
                    if (ack) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with state_q
    always_comb begin
        out_d         = '0;
        sub_sel       = SIGNED_EN && signed_mode && (cnt_d == LAST);
        out_d.busy    = state_d inside {INIT, TEST, ADD, SHIFT};
        out_d.done    = (state_d == DONE);
        out_d.rsclear = (state_d == INIT);
        out_d.mrld    = (state_d == INIT);
        out_d.mdld    = (state_d == INIT);
        out_d.rsload  = (state_d == ADD) && !sub_sel;
        out_d.rssub   = (state_d == ADD) && sub_sel;
        out_d.rsshr   = (state_d == SHIFT);
        ctrl_t_d      = !clear_t && (|{state_t_d, cnt_t_d});
        taint_seen_d  = taint_seen_q | ctrl_t_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q        <= '0;
            ctrl_t_q     <= 1'b0;
            taint_seen_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            ctrl_t_q     <= ctrl_t_d;
            taint_seen_q <= taint_seen_d;
        end
    end

    assign busy          = out_q.busy;
    assign productDone   = out_q.done;
    assign rsload        = out_q.rsload;
    assign rssub         = out_q.rssub;
    assign rsclear       = out_q.rsclear;
    assign rsshr         = out_q.rsshr;
    assign mrld          = out_q.mrld;
    assign mdld          = out_q.mdld;
    assign busy_t        = ctrl_t_q;
    assign productDone_t = ctrl_t_q;
    assign rsload_t      = ctrl_t_q;
    assign rssub_t       = ctrl_t_q;
    assign rsclear_t     = ctrl_t_q;
    assign rsshr_t       = ctrl_t_q;
    assign mrld_t        = ctrl_t_q;
    assign mdld_t        = ctrl_t_q;
    assign taint_seen    = taint_seen_q;

endmodule
